// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, reads program memory over a ready/valid
// handshake into the IR, and applies jump targets issued by the control unit.
module ifetch_unit #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [INSTR_W-1:0] ir,
  output logic [4:0]         opcode,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic                pend_valid_r;
  logic [ADDR_W-1:0]   pend_target_r;

  assign opcode = ir[INSTR_W-1 -: 5];
  assign busy   = (state_r != IDLE);

  // Fetch controller: a jump seen during a read is parked and applied when the read
  // completes; a jump arriving on the completing cycle itself is the most recent one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      pc            <= RESET_PC;
      ir            <= {INSTR_W{1'b0}};
      ir_valid      <= 1'b0;
      mem_rd        <= 1'b0;
      mem_addr      <= RESET_PC;
      pend_valid_r  <= 1'b0;
      pend_target_r <= {ADDR_W{1'b0}};
    end else begin
      ir_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          pend_valid_r <= 1'b0;
          if (fetch_req) begin
            state_r <= READ;
            mem_rd  <= 1'b1;
            if (jump_en) begin
              pc       <= jump_target;
              mem_addr <= jump_target;
            end else begin
              mem_addr <= pc;
            end
          end else if (jump_en) begin
            pc <= jump_target;
          end else begin
            pc <= pc;
          end
        end
        READ: begin
          if (mem_ready) begin
            ir           <= mem_rdata;
            ir_valid     <= 1'b1;
            mem_rd       <= 1'b0;
            state_r      <= IDLE;
            pend_valid_r <= 1'b0;
            if (jump_en) begin
              pc <= jump_target;
            end else if (pend_valid_r) begin
              pc <= pend_target_r;
            end else begin
              pc <= pc + PC_ONE;
            end
          end else if (jump_en) begin
            pend_valid_r  <= 1'b1;
            pend_target_r <= jump_target;
          end else begin
            pend_valid_r <= pend_valid_r;
          end
        end
        default: begin
          state_r <= IDLE;
          mem_rd  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit with a few hand-written reset sequences.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic        jump_en;
  logic [7:0]  jump_target;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] ir;
  logic [4:0]  opcode;
  logic        ir_valid;
  logic [7:0]  pc;
  logic        busy;

  ifetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .jump_en(jump_en),
    .jump_target(jump_target), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ir(ir), .opcode(opcode),
    .ir_valid(ir_valid), .pc(pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fr;
    logic        je;
    logic [7:0]  jt;
    logic        rdy;
    logic [15:0] rdata;
    logic        e_rd;
    logic [7:0]  e_addr;
    logic        e_iv;
    logic [15:0] e_ir;
    logic [4:0]  e_op;
    logic [7:0]  e_pc;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;
  int   step;

  task automatic add(input logic fr, input logic je, input logic [7:0] jt,
                     input logic rdy, input logic [15:0] rdata,
                     input logic e_rd, input logic [7:0] e_addr, input logic e_iv,
                     input logic [15:0] e_ir, input logic [4:0] e_op,
                     input logic [7:0] e_pc, input logic e_busy);
    vec_t v;
    v.fr = fr; v.je = je; v.jt = jt; v.rdy = rdy; v.rdata = rdata;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ir = e_ir;
    v.e_op = e_op; v.e_pc = e_pc; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    end
  endtask

  task automatic chk_all(input logic e_rd, input logic [7:0] e_addr, input logic e_iv,
                         input logic [15:0] e_ir, input logic [4:0] e_op,
                         input logic [7:0] e_pc, input logic e_busy);
    chk("mem_rd",   {15'h0000, mem_rd},   {15'h0000, e_rd});
    chk("mem_addr", {8'h00, mem_addr},    {8'h00, e_addr});
    chk("ir_valid", {15'h0000, ir_valid}, {15'h0000, e_iv});
    chk("ir",       ir,                   e_ir);
    chk("opcode",   {11'h000, opcode},    {11'h000, e_op});
    chk("pc",       {8'h00, pc},          {8'h00, e_pc});
    chk("busy",     {15'h0000, busy},     {15'h0000, e_busy});
  endtask

  task automatic drive(input logic fr, input logic je, input logic [7:0] jt,
                       input logic rdy, input logic [15:0] rdata);
    fetch_req = fr; jump_en = je; jump_target = jt; mem_ready = rdy; mem_rdata = rdata;
  endtask

  initial begin
    checks = 0; errors = 0; step = -1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);

    //  fr    je    jt     rdy   rdata      rd    addr   iv    ir         op        pc     busy
    // basic zero-wait fetch
    add(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 16'h0000, 5'b00000, 8'h00, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 16'h3A05, 1'b0, 8'h00, 1'b1, 16'h3A05, 5'b00111, 8'h01, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h3A05, 5'b00111, 8'h01, 1'b0);
    // three wait states, fetch_req held and garbage on rdata meanwhile
    add(1'b1, 1'b0, 8'h00, 1'b0, 16'hFFFF, 1'b1, 8'h01, 1'b0, 16'h3A05, 5'b00111, 8'h01, 1'b1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 16'hFFFF, 1'b1, 8'h01, 1'b0, 16'h3A05, 5'b00111, 8'h01, 1'b1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 16'hFFFF, 1'b1, 8'h01, 1'b0, 16'h3A05, 5'b00111, 8'h01, 1'b1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 16'hFFFF, 1'b1, 8'h01, 1'b0, 16'h3A05, 5'b00111, 8'h01, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 8'h01, 1'b1, 16'h1234, 5'b00010, 8'h02, 1'b0);
    // jump alone in IDLE, then jump together with fetch
    add(1'b0, 1'b1, 8'h05, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b0, 16'h1234, 5'b00010, 8'h05, 1'b0);
    add(1'b1, 1'b1, 8'h40, 1'b0, 16'h0000, 1'b1, 8'h40, 1'b0, 16'h1234, 5'b00010, 8'h40, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 16'hA0F0, 1'b0, 8'h40, 1'b1, 16'hA0F0, 5'b10100, 8'h41, 1'b0);
    // jump during READ: last pending target wins, read still from addr 3
    add(1'b0, 1'b1, 8'h03, 1'b0, 16'h0000, 1'b0, 8'h40, 1'b0, 16'hA0F0, 5'b10100, 8'h03, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h03, 1'b0, 16'hA0F0, 5'b10100, 8'h03, 1'b1);
    add(1'b0, 1'b1, 8'h10, 1'b0, 16'h0000, 1'b1, 8'h03, 1'b0, 16'hA0F0, 5'b10100, 8'h03, 1'b1);
    add(1'b0, 1'b1, 8'h20, 1'b0, 16'h0000, 1'b1, 8'h03, 1'b0, 16'hA0F0, 5'b10100, 8'h03, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 16'h5555, 1'b0, 8'h03, 1'b1, 16'h5555, 5'b01010, 8'h20, 1'b0);
    // PC wrap at 8'hFF
    add(1'b0, 1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'h03, 1'b0, 16'h5555, 5'b01010, 8'hFF, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'hFF, 1'b0, 16'h5555, 5'b01010, 8'hFF, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 16'hF801, 1'b0, 8'hFF, 1'b1, 16'hF801, 5'b11111, 8'h00, 1'b0);
    // mem_ready while IDLE must not load IR; start a fetch to abort with reset
    add(1'b1, 1'b0, 8'h00, 1'b1, 16'hDEAD, 1'b1, 8'h00, 1'b0, 16'hF801, 5'b11111, 8'h00, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b0, 16'hDEAD, 1'b1, 8'h00, 1'b0, 16'hF801, 5'b11111, 8'h00, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk_all(1'b0, 8'h00, 1'b0, 16'h0000, 5'b00000, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step = i;
      @(negedge clk);
      drive(vecs[i].fr, vecs[i].je, vecs[i].jt, vecs[i].rdy, vecs[i].rdata);
      @(posedge clk);
      #1;
      chk_all(vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_iv, vecs[i].e_ir,
              vecs[i].e_op, vecs[i].e_pc, vecs[i].e_busy);
    end

    // reset asserted mid-READ aborts the fetch
    step = 100;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all(1'b0, 8'h00, 1'b0, 16'h0000, 5'b00000, 8'h00, 1'b0);
    // late mem_ready after release must be ignored
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 16'hBEEF);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step = 101 + k;
      @(posedge clk);
      #1;
      chk_all(1'b0, 8'h00, 1'b0, 16'h0000, 5'b00000, 8'h00, 1'b0);
    end

    // fetch after reset starts cleanly from RESET_PC again
    step = 110;
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 16'h0800);
    @(posedge clk);
    #1;
    chk_all(1'b1, 8'h00, 1'b0, 16'h0000, 5'b00000, 8'h00, 1'b1);
    step = 111;
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 16'h0800);
    @(posedge clk);
    #1;
    chk_all(1'b0, 8'h00, 1'b1, 16'h0800, 5'b00001, 8'h01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
